// File: rtl/hit_tracker_pkg.sv
// Shared definitions for the hit tracker.
// Purpose: state encoding of the damage FSM, default game tuning values that
//          the HP display logic also uses, and a small sizing helper.
// Ports:   none (package).
package hit_tracker_pkg;

  // Damage FSM states; the encoding is shared with the HP display logic.
  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hit_state_t;

  localparam int unsigned HP_MAX_DEFAULT        = 20;
  localparam int unsigned DAMAGE_DEFAULT        = 4;
  localparam int unsigned INVULN_FRAMES_DEFAULT = 60;
  localparam int unsigned BLINK_FRAMES_DEFAULT  = 4;

  // Bits needed to hold 0..frames-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/hit_tracker_frame_down_counter.sv
// Frame down-counter for the invulnerability window.
// Purpose: loadable down-counter advanced once per frame, with a zero flag and
//          the blink phase derived from the counter's next value so the
//          parent can register its heart-visibility output in step with the
//          state change.
// Ports:
//   clk        in   system clock
//   rst_n      in   async reset, active low
//   clear      in   force count to 0 (restart)
//   load       in   load FRAMES-1 (start of invulnerability)
//   advance    in   end-of-frame step; decrements, holding at 0
//   zero       out  current count is 0
//   hide_next  out  heart hidden for the count value taking effect next edge
module hit_tracker_frame_down_counter
  import hit_tracker_pkg::*;
#(
  parameter int unsigned FRAMES = INVULN_FRAMES_DEFAULT,
  parameter int unsigned BLINK  = BLINK_FRAMES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic advance,
  output logic zero,
  output logic hide_next
);

  localparam int unsigned W = cnt_width(FRAMES);

  logic [W-1:0] count;
  logic [W-1:0] count_d;
  logic [W-1:0] elapsed;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    count_d = count;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = W'(FRAMES - 1);
    end else if (advance && (count != '0)) begin
      count_d = count - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

  assign zero = (count == '0);

  // Frames elapsed since the hit; the heart is hidden in even blink periods.
  assign elapsed   = W'(FRAMES - 1) - count_d;
  assign hide_next = ((elapsed / W'(BLINK)) & W'(1)) == '0;

endmodule

// File: rtl/hit_tracker.sv
// Hit tracker: turns pixel-level ball/heart overlap into per-frame damage.
// Purpose: latches any ball/heart overlap seen during a frame, applies damage
//          at end of frame, runs an invulnerability window with a blinking
//          heart, and reports game over. All outputs are registered.
// Ports:
//   i_clk        in   system clock
//   i_rst_n      in   async reset, active low
//   i_pix_stb    in   pixel strobe; coverage inputs valid only when high
//   i_animate    in   1-cycle end-of-frame pulse
//   i_heart_on   in   current pixel inside the heart
//   i_ball_on    in   current pixel inside ball k (bit k)
//   i_restart    in   1-cycle restart request
//   o_hp         out  current HP
//   o_hit        out  1-cycle pulse when damage is applied
//   o_invuln     out  high while invulnerable
//   o_heart_vis  out  heart-draw enable (blink gating)
//   o_game_over  out  high when dead
module hit_tracker
  import hit_tracker_pkg::*;
#(
  parameter int unsigned N_BALLS       = 3,
  parameter int unsigned HP_W          = 8,
  parameter int unsigned HP_MAX        = HP_MAX_DEFAULT,
  parameter int unsigned DAMAGE        = DAMAGE_DEFAULT,
  parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEFAULT,
  parameter int unsigned BLINK_FRAMES  = BLINK_FRAMES_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic               i_heart_on,
  input  logic [N_BALLS-1:0] i_ball_on,
  input  logic               i_restart,
  output logic [HP_W-1:0]    o_hp,
  output logic               o_hit,
  output logic               o_invuln,
  output logic               o_heart_vis,
  output logic               o_game_over
);

  hit_state_t      state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            latch_q, latch_d;
  logic            overlap;
  logic            hit_d;
  logic            invuln_d, heart_vis_d, game_over_d;
  logic            cnt_load, cnt_advance, cnt_zero, cnt_hide_next;

  assign overlap = i_pix_stb & i_heart_on & (|i_ball_on);

  // Overlap on the animate cycle itself belongs to the frame that starts there.
  always_comb begin
    latch_d = latch_q | overlap;
    if (i_restart) begin
      latch_d = 1'b0;
    end else if (i_animate) begin
      latch_d = overlap;
    end
  end

  hit_tracker_frame_down_counter #(
    .FRAMES (INVULN_FRAMES),
    .BLINK  (BLINK_FRAMES)
  ) u_frame_down_counter (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (i_restart),
    .load      (cnt_load),
    .advance   (cnt_advance),
    .zero      (cnt_zero),
    .hide_next (cnt_hide_next)
  );

  assign cnt_advance = i_animate & ~i_restart & (state_q == INVULN);

  // Next-state logic: evaluated only at end of frame, restart takes priority.
  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    hit_d    = 1'b0;
    cnt_load = 1'b0;
    if (i_restart) begin
      state_d = ALIVE;
      hp_d    = HP_W'(HP_MAX);
    end else if (i_animate) begin
      case (state_q)
        ALIVE: begin
          if (latch_q) begin
            hit_d = 1'b1;
            // Saturating subtract: a hit that would reach or pass 0 kills.
            if (hp_q <= HP_W'(DAMAGE)) begin
              hp_d    = '0;
              state_d = DEAD;
            end else begin
              hp_d     = hp_q - HP_W'(DAMAGE);
              cnt_load = 1'b1;
              state_d  = INVULN;
            end
          end
        end
        INVULN: begin
          if (cnt_zero) begin
            state_d = ALIVE;
          end
        end
        DEAD: begin
          hp_d = '0;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end
  end

  // Output logic, computed from the next state so the outputs are registered.
  always_comb begin
    invuln_d    = (state_d == INVULN);
    game_over_d = (state_d == DEAD);
    heart_vis_d = (state_d == INVULN) ? ~cnt_hide_next : 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ALIVE;
      hp_q        <= HP_W'(HP_MAX);
      latch_q     <= 1'b0;
      o_hit       <= 1'b0;
      o_invuln    <= 1'b0;
      o_heart_vis <= 1'b1;
      o_game_over <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      latch_q     <= latch_d;
      o_hit       <= hit_d;
      o_invuln    <= invuln_d;
      o_heart_vis <= heart_vis_d;
      o_game_over <= game_over_d;
    end
  end

  assign o_hp = hp_q;

endmodule

// File: tb/tb_hit_tracker.sv
// Self-checking bench for hit_tracker: randomized frames checked every cycle
// against a frame-level model (HP count, mode, frames since last hit).
module tb_hit_tracker;

  localparam int HP_MAX  = 20;
  localparam int DAMAGE  = 4;
  localparam int IFRAMES = 60;
  localparam int BLINK   = 4;

  localparam int M_ALIVE  = 0;
  localparam int M_INVULN = 1;
  localparam int M_DEAD   = 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_pix_stb;
  logic       i_animate;
  logic       i_heart_on;
  logic [2:0] i_ball_on;
  logic       i_restart;
  logic [7:0] o_hp;
  logic       o_hit;
  logic       o_invuln;
  logic       o_heart_vis;
  logic       o_game_over;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_hp;
  int m_mode;
  int m_elapsed;
  bit m_pending;
  bit m_hit;

  hit_tracker dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_pix_stb   (i_pix_stb),
    .i_animate   (i_animate),
    .i_heart_on  (i_heart_on),
    .i_ball_on   (i_ball_on),
    .i_restart   (i_restart),
    .o_hp        (o_hp),
    .o_hit       (o_hit),
    .o_invuln    (o_invuln),
    .o_heart_vis (o_heart_vis),
    .o_game_over (o_game_over)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hp      = HP_MAX;
    m_mode    = M_ALIVE;
    m_elapsed = 0;
    m_pending = 1'b0;
    m_hit     = 1'b0;
  endtask

  task automatic compare_all();
    bit vis;
    vis = (m_mode != M_INVULN) || (((m_elapsed / BLINK) % 2) == 1);
    check("hp", o_hp, m_hp);
    check("hit", o_hit, m_hit);
    check("invuln", o_invuln, m_mode == M_INVULN);
    check("heart_vis", o_heart_vis, vis);
    check("game_over", o_game_over, m_mode == M_DEAD);
  endtask

  // One clock: apply inputs, step the model, compare just after the edge.
  task automatic cycle(input bit pix, input bit heart, input logic [2:0] ball,
                       input bit anim, input bit rst);
    bit ov;
    i_pix_stb  = pix;
    i_heart_on = heart;
    i_ball_on  = ball;
    i_animate  = anim;
    i_restart  = rst;
    @(posedge i_clk);
    #1;
    ov    = pix & heart & (|ball);
    m_hit = 1'b0;
    if (rst) begin
      model_reset();
    end else if (anim) begin
      if (m_mode == M_ALIVE && m_pending) begin
        m_hit = 1'b1;
        m_hp  = (m_hp > DAMAGE) ? m_hp - DAMAGE : 0;
        m_mode    = (m_hp == 0) ? M_DEAD : M_INVULN;
        m_elapsed = 0;
      end else if (m_mode == M_INVULN) begin
        m_elapsed++;
        if (m_elapsed == IFRAMES) m_mode = M_ALIVE;
      end
      m_pending = ov;
    end else begin
      m_pending = m_pending | ov;
    end
    compare_all();
  endtask

  // Random pixel inputs, either a guaranteed overlap or guaranteed none.
  task automatic gen_pixel(input bit want_ov, output bit pix, output bit heart,
                           output logic [2:0] ball);
    if (want_ov) begin
      pix   = 1'b1;
      heart = 1'b1;
      ball  = 3'($urandom_range(1, 7));
    end else begin
      pix   = 1'($urandom);
      heart = 1'($urandom);
      ball  = 3'($urandom);
      if (pix & heart & (|ball)) begin
        case ($urandom_range(0, 2))
          0:       pix   = 1'b0;
          1:       heart = 1'b0;
          default: ball  = 3'b000;
        endcase
      end
    end
  endtask

  // policy: 0 no overlap, 1 exactly one overlapping pixel, 2 fully random.
  task automatic run_frame(input int policy, input bit anim_ov,
                           input bit restart_at_anim, input int restart_cycle);
    int         len;
    int         k;
    bit         pix, heart;
    logic [2:0] ball;
    len = $urandom_range(6, 14);
    k   = $urandom_range(0, len - 1);
    for (int i = 0; i < len; i++) begin
      if (policy == 2) begin
        pix   = 1'($urandom);
        heart = 1'($urandom);
        ball  = 3'($urandom);
      end else begin
        gen_pixel(policy == 1 && i == k, pix, heart, ball);
      end
      cycle(pix, heart, ball, 1'b0, i == restart_cycle);
    end
    gen_pixel(anim_ov, pix, heart, ball);
    cycle(pix, heart, ball, 1'b1, restart_at_anim);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_pix_stb  = 1'b0;
    i_animate  = 1'b0;
    i_heart_on = 1'b0;
    i_ball_on  = 3'b000;
    i_restart  = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    compare_all();
    i_rst_n = 1'b1;

    // Single overlap pixel, then ride out the whole blink/invulnerable window.
    run_frame(1, 1'b0, 1'b0, -1);
    for (int f = 0; f < 64; f++) run_frame(0, 1'b0, 1'b0, -1);

    // Overlap every frame until dead, HP then held at 0.
    for (int f = 0; f < 200; f++) run_frame(1, 1'b0, 1'b0, -1);
    check("dead_hp", o_hp, 0);
    check("dead_flag", o_game_over, 1'b1);

    // Restart from DEAD mid-frame.
    run_frame(0, 1'b0, 1'b0, 3);
    check("restart_hp", o_hp, HP_MAX);

    // Decoys only: strobe low or heart without ball.
    for (int f = 0; f < 10; f++) run_frame(0, 1'b0, 1'b0, -1);

    // Overlap only on the animate cycle: counted at the following animate.
    run_frame(0, 1'b1, 1'b0, -1);
    run_frame(0, 1'b0, 1'b0, -1);
    for (int f = 0; f < 62; f++) run_frame(0, 1'b0, 1'b0, -1);

    // Restart on the same cycle as a pending hit.
    run_frame(1, 1'b0, 1'b1, -1);
    run_frame(0, 1'b0, 1'b0, -1);

    // Asynchronous reset in the middle of invulnerability.
    run_frame(1, 1'b0, 1'b0, -1);
    for (int f = 0; f < 5; f++) run_frame(0, 1'b0, 1'b0, -1);
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge i_clk);
    #1;
    compare_all();
    i_rst_n = 1'b1;

    // Randomized frames with occasional restarts.
    for (int f = 0; f < 300; f++) begin
      int pol;
      pol = ($urandom_range(0, 9) < 6) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 2);
      run_frame(pol, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                ($urandom_range(0, 29) == 0) ? 2 : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
